// File: rtl/fxp_pkg.sv
// ---------------------------------------------------------------------------
// fxp_pkg
//   Shared definitions for the fixed-point datapath blocks (fxp_mul_pipe and
//   the align/round/saturate stage fxp_round_sat).
//   - Rounding-mode encodings carried with every beat. Code 2'b11 is not
//     listed here and is treated as truncation.
//   - fxp_width(i, f): total bit width of a Qi.f number.
// ---------------------------------------------------------------------------
package fxp_pkg;

    localparam logic [1:0] RND_TRUNC = 2'b00;
    localparam logic [1:0] RND_HUP   = 2'b01;
    localparam logic [1:0] RND_HEVEN = 2'b10;

    function automatic int fxp_width(input int i, input int f);
        return i + f;
    endfunction

endpackage

// File: rtl/fxp_round_sat.sv
// ---------------------------------------------------------------------------
// fxp_round_sat
//   Combinational align / round / saturate from a QIN_I.IN_F value to a
//   QOUT_I.OUT_F value. Signedness and rounding mode are chosen per call.
//   Ports:
//     din_i   in   IN_W    source value (two's complement when sign_i=1)
//     sign_i  in   1       1: signed source and result, 0: unsigned
//     rnd_i   in   2       rounding mode (fxp_pkg RND_*; 2'b11 truncates)
//     dout_o  out  OUT_W   aligned, rounded, saturated result
//     ovf_o   out  1       result was clamped to a range bound
//     unf_o   out  1       nonzero bits were dropped below the output LSB
// ---------------------------------------------------------------------------
module fxp_round_sat
    import fxp_pkg::*;
#(
    parameter  int IN_I  = 7,
    parameter  int IN_F  = 4,
    parameter  int OUT_I = 5,
    parameter  int OUT_F = 3,
    localparam int IN_W  = fxp_width(IN_I, IN_F),
    localparam int OUT_W = fxp_width(OUT_I, OUT_F)
) (
    input  logic [IN_W-1:0]  din_i,
    input  logic             sign_i,
    input  logic [1:0]       rnd_i,
    output logic [OUT_W-1:0] dout_o,
    output logic             ovf_o,
    output logic             unf_o
);

    // LSH: left shift when the output has more fraction bits.
    // D:   number of fraction bits dropped when it has fewer.
    localparam int LSH = (OUT_F > IN_F) ? OUT_F - IN_F : 0;
    localparam int D   = (IN_F > OUT_F) ? IN_F - OUT_F : 0;
    // Working width: the wider of source/result, the left shift, one guard
    // bit for the rounding carry and one bit so unsigned values stay positive
    // when handled as signed.
    localparam int EW  = ((IN_W > OUT_W) ? IN_W : OUT_W) + LSH + 2;

    localparam logic signed [EW-1:0] ONE  = {{(EW-1){1'b0}}, 1'b1};
    localparam logic signed [EW-1:0] ZERO = '0;
    localparam logic signed [EW-1:0] SMAX = (ONE <<< (OUT_W-1)) - ONE;
    localparam logic signed [EW-1:0] SMIN = -(ONE <<< (OUT_W-1));
    localparam logic signed [EW-1:0] UMAX = (ONE <<< OUT_W) - ONE;

    logic signed [EW-1:0] ext;
    logic signed [EW-1:0] aligned;
    logic signed [EW-1:0] hi;
    logic signed [EW-1:0] lo;

    // Sign- or zero-extend so one signed compare covers both modes.
    assign ext = {{(EW-IN_W){sign_i & din_i[IN_W-1]}}, din_i};

    generate
        if (D == 0) begin : g_lsh
            assign aligned = ext <<< LSH;
            assign unf_o   = 1'b0;
        end else begin : g_rnd
            logic [D-1:0]         disc;
            logic                 sticky;
            logic                 inc;
            logic signed [EW-1:0] kept;

            assign disc = din_i[D-1:0];
            // Arithmetic shift floors, which is truncation in both modes.
            assign kept = ext >>> D;

            // sticky: any dropped bit below the half position
            if (D > 1) begin : g_sticky
                assign sticky = |disc[D-2:0];
            end else begin : g_nosticky
                assign sticky = 1'b0;
            end

            // Adding half and flooring equals adding 1 when disc >= half.
            always_comb begin
                inc = 1'b0;
                unique case (rnd_i)
                    RND_HUP:   inc = disc[D-1];
                    RND_HEVEN: inc = disc[D-1] & (sticky | kept[0]);
                    default:   inc = 1'b0;
                endcase
            end

            assign aligned = kept + {{(EW-1){1'b0}}, inc};
            assign unf_o   = |disc;
        end
    endgenerate

    assign hi = sign_i ? SMAX : UMAX;
    assign lo = sign_i ? SMIN : ZERO;

    always_comb begin
        dout_o = aligned[OUT_W-1:0];
        ovf_o  = 1'b0;
        if (aligned > hi) begin
            dout_o = hi[OUT_W-1:0];
            ovf_o  = 1'b1;
        end else if (aligned < lo) begin
            dout_o = lo[OUT_W-1:0];
            ovf_o  = 1'b1;
        end
    end

endmodule

// File: rtl/fxp_mul_pipe.sv
// ---------------------------------------------------------------------------
// fxp_mul_pipe
//   3-stage pipelined fixed-point multiplier with valid/ready streams.
//   S1 captures operands and per-beat controls, S2 the exact product,
//   S3 the aligned/rounded/saturated result that drives the outputs.
//   A stalled consumer freezes the whole pipeline (single global enable).
//   Ports:
//     clk        in   1        rising-edge clock
//     rst_n      in   1        asynchronous active-low reset
//     in_valid   in   1        operand beat valid
//     in_ready   out  1        operand beat accepted this cycle when valid
//     a          in   AW       operand a, QA_I.A_F
//     b          in   BW       operand b, QB_I.B_F
//     sign       in   1        1: signed operation, 0: unsigned
//     rnd        in   2        rounding mode for this beat
//     out_valid  out  1        result beat valid
//     out_ready  in   1        consumer takes the result
//     out        out  OW       result, QO_I.O_F
//     overflow   out  1        result saturated
//     underflow  out  1        nonzero bits discarded below result LSB
//     sat_cnt    out  CNT_W    delivered overflow beats, saturating
// ---------------------------------------------------------------------------
module fxp_mul_pipe
    import fxp_pkg::*;
#(
    parameter  int A_I   = 3,
    parameter  int A_F   = 2,
    parameter  int B_I   = 4,
    parameter  int B_F   = 2,
    parameter  int O_I   = 5,
    parameter  int O_F   = 3,
    parameter  int CNT_W = 16,
    localparam int AW    = fxp_width(A_I, A_F),
    localparam int BW    = fxp_width(B_I, B_F),
    localparam int OW    = fxp_width(O_I, O_F)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [AW-1:0]    a,
    input  logic [BW-1:0]    b,
    input  logic             sign,
    input  logic [1:0]       rnd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OW-1:0]    out,
    output logic             overflow,
    output logic             underflow,
    output logic [CNT_W-1:0] sat_cnt
);

    localparam int PI     = A_I + B_I;
    localparam int PF     = A_F + B_F;
    localparam int PW     = fxp_width(PI, PF);
    localparam int STAGES = 3;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [BW-1:0] b;
        logic          sgn;
        logic [1:0]    rnd;
    } s1_t;

    typedef struct packed {
        logic [PW-1:0] p;
        logic          sgn;
        logic [1:0]    rnd;
    } s2_t;

    typedef struct packed {
        logic [OW-1:0] res;
        logic          ovf;
        logic          unf;
    } s3_t;

    // vld_q[0] = S1 ... vld_q[STAGES-1] = S3 (drives out_valid)
    logic [STAGES-1:0] vld_q, vld_d;
    s1_t               s1_q, s1_d;
    s2_t               s2_q, s2_d;
    s3_t               s3_q, s3_d;
    logic [CNT_W-1:0]  sat_cnt_q, sat_cnt_d;

    logic              stall;
    logic              adv;
    logic [PW-1:0]     a_x;
    logic [PW-1:0]     b_x;
    logic [OW-1:0]     rs_res;
    logic              rs_ovf;
    logic              rs_unf;

    assign stall    = vld_q[STAGES-1] & ~out_ready;
    assign adv      = ~stall;
    assign in_ready = adv;

    // Extending both operands to the full product width and keeping the low
    // PW bits of the product gives the exact result in either mode.
    assign a_x = {{(PW-AW){s1_q.sgn & s1_q.a[AW-1]}}, s1_q.a};
    assign b_x = {{(PW-BW){s1_q.sgn & s1_q.b[BW-1]}}, s1_q.b};

    fxp_round_sat #(
        .IN_I  (PI),
        .IN_F  (PF),
        .OUT_I (O_I),
        .OUT_F (O_F)
    ) u_round_sat (
        .din_i  (s2_q.p),
        .sign_i (s2_q.sgn),
        .rnd_i  (s2_q.rnd),
        .dout_o (rs_res),
        .ovf_o  (rs_ovf),
        .unf_o  (rs_unf)
    );

    always_comb begin
        vld_d = {vld_q[STAGES-2:0], in_valid};
        s1_d  = '{a: a, b: b, sgn: sign, rnd: rnd};
        s2_d  = '{p: a_x * b_x, sgn: s1_q.sgn, rnd: s1_q.rnd};
        s3_d  = '{res: rs_res, ovf: rs_ovf, unf: rs_unf};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            s1_q  <= '0;
            s2_q  <= '0;
            s3_q  <= '0;
        end else if (adv) begin
            vld_q <= vld_d;
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            s3_q  <= s3_d;
        end
    end

    // Counts overflow beats on delivery, not on computation, so a stalled
    // beat is counted exactly once.
    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (vld_q[STAGES-1] & out_ready & s3_q.ovf & ~&sat_cnt_q)
            sat_cnt_d = sat_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sat_cnt_q <= '0;
        else        sat_cnt_q <= sat_cnt_d;
    end

    assign out_valid = vld_q[STAGES-1];
    assign out       = s3_q.res;
    assign overflow  = s3_q.ovf;
    assign underflow = s3_q.unf;
    assign sat_cnt   = sat_cnt_q;

endmodule
